// File: rtl/cntr_pkg.sv
// cntr_pkg: shared constants and next-action encoding for the up/down counter
// Contents: default width, direction constants, action enum.
package cntr_pkg;
    localparam int WIDTH_DEF = 8;
    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;
    typedef enum logic [2:0] {HOLD, CLR, LOAD, INC, DEC} act_t;
endpackage

// File: rtl/cntr_nxt.sv
// cntr_nxt: combinational next-count value and limit detection
// Ports: cur (current count), din (load value), clr/load/en/up (controls),
//        nxt (next count), wrap (count crossed a limit and wrapped),
//        block (count held at a limit).
// Macro: CNTR_SAT_EN selects saturating mode instead of wrap mode.
module cntr_nxt
    import cntr_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter logic [WIDTH-1:0] MAX = '1
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] din,
    input  logic             clr,
    input  logic             load,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] nxt,
    output logic             wrap,
    output logic             block
);
    localparam logic [WIDTH:0] MAXW = {1'b0, MAX};
`ifdef CNTR_SAT_EN
    localparam logic [WIDTH-1:0] TOP = MAX;
    localparam logic [WIDTH-1:0] BOT = '0;
`else
    localparam logic [WIDTH-1:0] TOP = '0;
    localparam logic [WIDTH-1:0] BOT = MAX;
`endif
    act_t act;
    logic [WIDTH:0] inc, dec;
    logic lim;
    // The extra bit catches overflow above MAX and borrow below 0.
    always_comb begin
        act = clr ? CLR : load ? LOAD : en ? (up == CNT_UP ? INC : DEC) : HOLD;
        inc = {1'b0, cur} + 1'b1;
        dec = {1'b0, cur} - 1'b1;
        lim = (act == INC && inc > MAXW) || (act == DEC && dec[WIDTH]);
        nxt = act == CLR  ? '0 :
              act == LOAD ? (din > MAX ? MAX : din) :
              act == INC  ? (lim ? TOP : inc[WIDTH-1:0]) :
              act == DEC  ? (lim ? BOT : dec[WIDTH-1:0]) : cur;
    end
`ifdef CNTR_SAT_EN
    assign wrap  = 1'b0;
    assign block = lim;
`else
    assign wrap  = lim;
    assign block = 1'b0;
`endif
endmodule

// File: rtl/cntr_updn_mod.sv
// cntr_updn_mod: registered up/down counter with clear, load and limit pulses
// Ports: clk, nrst (async active-low), en, up, clr, load, din,
//        dout (count), tc (wrap pulse), sat (saturation pulse).
// Macro: CNTR_SAT_EN selects saturating mode; otherwise wraps and sat stays 0.
module cntr_updn_mod
    import cntr_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter logic [WIDTH-1:0] MAX = '1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             tc,
    output logic             sat
);
    logic [WIDTH-1:0] nxt;
    logic wrap, block;
    cntr_nxt #(.WIDTH(WIDTH), .MAX(MAX)) u_nxt (
        .cur(dout), .din(din), .clr(clr), .load(load), .en(en), .up(up),
        .nxt(nxt), .wrap(wrap), .block(block)
    );
    // block is constant 0 in wrap mode, so sat reduces to a constant 0.
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            dout <= '0;
            tc   <= 1'b0;
            sat  <= 1'b0;
        end else begin
            dout <= nxt;
            tc   <= wrap;
            sat  <= block;
        end
endmodule

// File: tb/tb_cntr_updn_mod.sv
// tb_cntr_updn_mod: scoreboard bench for cntr_updn_mod (4-bit/MAX=9 and 8-bit/MAX=255)
module tb_cntr_updn_mod;
`ifdef CNTR_SAT_EN
    localparam bit S = 1'b1;
`else
    localparam bit S = 1'b0;
`endif
    typedef struct {
        string      nm;
        bit         sel;
        logic [7:0] d;
        logic       tc;
        logic       sat;
    } exp_t;

    logic clk = 1'b0, nrst = 1'b1, en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
    logic [7:0] din = '0;
    logic [3:0] dout4;
    logic [7:0] dout8;
    logic tc4, sat4, tc8, sat8;
    exp_t sb[$];
    event mon_ev;
    int pass = 0, total = 0;

    always #5 clk = ~clk;

    cntr_updn_mod #(.WIDTH(4), .MAX(4'd9)) dut4 (
        .clk(clk), .nrst(nrst), .en(en), .up(up), .clr(clr), .load(load),
        .din(din[3:0]), .dout(dout4), .tc(tc4), .sat(sat4)
    );
    cntr_updn_mod #(.WIDTH(8), .MAX(8'd255)) dut8 (
        .clk(clk), .nrst(nrst), .en(en), .up(up), .clr(clr), .load(load),
        .din(din), .dout(dout8), .tc(tc8), .sat(sat8)
    );

    task automatic push(input string nm, input bit s, input logic [7:0] ed, input logic et, input logic es);
        exp_t x;
        x.nm = nm; x.sel = s; x.d = ed; x.tc = et; x.sat = es;
        sb.push_back(x);
    endtask

    task automatic drive(input string nm, input bit c, input bit l, input bit e, input bit u,
                         input logic [7:0] d, input bit s, input logic [7:0] ed, input logic et, input logic es);
        @(negedge clk);
        nrst = 1'b1; clr = c; load = l; en = e; up = u; din = d;
        push(nm, s, ed, et, es);
    endtask

    // Monitor: after each rising edge (or an async reset probe), check every pending expectation.
    initial forever begin
        exp_t x;
        logic [7:0] ad;
        logic at, as;
        @(posedge clk or mon_ev);
        #1;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            ad = x.sel ? dout8 : {4'b0, dout4};
            at = x.sel ? tc8 : tc4;
            as = x.sel ? sat8 : sat4;
            total++;
            if ({ad, at, as} === {x.d, x.tc, x.sat}) pass++;
            else $display("FAIL %s: got dout=%0d tc=%b sat=%b, expected dout=%0d tc=%b sat=%b",
                          x.nm, ad, at, as, x.d, x.tc, x.sat);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        #1 nrst = 1'b0;
        #1 push("rst4", 1'b0, 8'd0, 1'b0, 1'b0);
        push("rst8", 1'b1, 8'd0, 1'b0, 1'b0);
        -> mon_ev;
        for (int i = 1; i <= 10; i++)
            drive("up_seq", 0, 0, 1, 1, 0, 0, i == 10 ? (S ? 8'd9 : 8'd0) : 8'(i), i == 10 && !S, i == 10 && S);
        drive("clr_en", 1, 0, 1, 1, 0, 0, 0, 0, 0);
        drive("dn_wrap", 0, 0, 1, 0, 0, 0, S ? 8'd0 : 8'd9, !S, S);
        drive("dn_next", 0, 0, 1, 0, 0, 0, S ? 8'd0 : 8'd8, 0, S);
        v = S ? 8'd0 : 8'd8;
        for (int i = 0; i < 5; i++)
            drive("hold", 0, 0, 0, i[0], 0, 0, v, 0, 0);
        drive("load_clamp", 0, 1, 1, 1, 12, 0, 9, 0, 0);
        drive("up_max", 0, 0, 1, 1, 0, 0, S ? 8'd9 : 8'd0, !S, S);
        drive("up_max2", 0, 0, 1, 1, 0, 0, S ? 8'd9 : 8'd1, 0, S);
        drive("load0", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        drive("load9", 0, 1, 0, 0, 9, 0, 9, 0, 0);
        drive("clr_load", 1, 1, 0, 0, 5, 0, 0, 0, 0);
        drive("load5", 0, 1, 0, 0, 5, 0, 5, 0, 0);
        @(posedge clk);
        #3 nrst = 1'b0;
        push("rst_mid", 1'b0, 8'd0, 1'b0, 1'b0);
        -> mon_ev;
        drive("rst_rel", 0, 0, 1, 1, 0, 0, 1, 0, 0);
        drive("w8_load", 0, 1, 0, 0, 255, 1, 255, 0, 0);
        drive("w8_wrap", 0, 0, 1, 1, 0, 1, S ? 8'd255 : 8'd0, !S, S);
        drive("w8_next", 0, 0, 1, 1, 0, 1, S ? 8'd255 : 8'd1, 0, S);
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/cntr_updn_mod.md
CNTR_UPDN_MOD -- requirements
Module: cntr_updn_mod

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits; legal range 2..32.
REQ-002 Parameter MAX, default 2**WIDTH-1: highest count value; legal range 1..2**WIDTH-1; count range is 0..MAX inclusive.
REQ-003 Port clk  input  1  clock; all state changes on the rising edge.
REQ-004 Port nrst  input  1  reset: asynchronous, active-low.
REQ-005 Port en  input  1  count enable.
REQ-006 Port up  input  1  direction: 1 counts up, 0 counts down.
REQ-007 Port clr  input  1  synchronous clear to 0.
REQ-008 Port load  input  1  synchronous parallel load of din.
REQ-009 Port din  input  WIDTH  load value.
REQ-010 Port dout  output  WIDTH  registered count value.
REQ-011 Port tc  output  1  registered terminal-count pulse on wrap.
REQ-012 Port sat  output  1  registered saturation pulse; constant 0 when CNTR_SAT_EN is undefined.

Function
REQ-013 Per-edge priority SHALL be: clr, then load, then en, then hold.
REQ-014 clr=1 SHALL set dout=0 on the next edge, regardless of load, en and up.
REQ-015 load=1 (clr=0) SHALL set dout=din on the next edge if din<=MAX, else dout=MAX.
REQ-016 en=1 (clr=0, load=0) SHALL add 1 to dout when up=1 and subtract 1 when up=0; single-cycle latency.
REQ-017 en=0 (clr=0, load=0) SHALL hold dout; up is ignored.
REQ-018 Up-count from MAX SHALL wrap to 0; down-count from 0 SHALL wrap to MAX (wrap mode).
REQ-019 tc SHALL be 1 for exactly the one cycle following an edge on which a wrap occurred; otherwise 0.
REQ-020 tc SHALL be 0 after a clr or load edge, even when the loaded value equals 0 or MAX.
REQ-021 Arithmetic SHALL be computed in WIDTH+1 bits so that MAX=2**WIDTH-1 wraps with no overflow artefact.
REQ-022 With a constant up and en=1, tc SHALL pulse once every MAX+1 cycles.

Reset
REQ-023 nrst=0 SHALL immediately force dout=0, tc=0 and sat=0, without waiting for a clock edge.
REQ-024 Reset asserted mid-count SHALL discard the count; the first enabled edge after deassertion SHALL count from 0.
REQ-025 All flops SHALL be on the asynchronous reset; no other reset path exists.

Configuration
REQ-026 Macro CNTR_SAT_EN defined SHALL select saturating mode: up at MAX holds MAX and down at 0 holds 0, with no wrap and tc stays 0.
REQ-027 With CNTR_SAT_EN defined, sat SHALL be 1 for the one cycle following an edge on which a count was blocked at a limit.
REQ-028 With CNTR_SAT_EN undefined, wrap mode (REQ-018, REQ-019) SHALL apply and sat SHALL be tied to 0.

Structure
REQ-029 A shared package cntr_pkg SHALL hold the default WIDTH constant, the direction constants CNT_UP=1 and CNT_DN=0, and an enum for the next-action encoding {HOLD, CLR, LOAD, INC, DEC}.
REQ-030 The combinational next-value and limit-detect logic SHALL be a sub-module cntr_nxt, with outputs nxt, wrap and block; cntr_updn_mod SHALL own all registers.

Verification (WIDTH=4, MAX=9 unless stated)
REQ-031 en=1, up=1, 10 edges from 0 -> dout sequence 1..9,0; tc=1 only in the cycle dout=0.
REQ-032 dout=0, en=1, up=0, 1 edge -> dout=9, tc=1 for one cycle; a further edge -> dout=8, tc=0.
REQ-033 load=1, din=12 -> dout=9, tc=0; load=1 and clr=1 on the same edge -> dout=0.
REQ-034 dout=5, nrst pulsed low between edges -> dout=0 immediately; after release, en=1, up=1, 1 edge -> dout=1.
REQ-035 en=0 with up toggling for 5 edges -> dout unchanged; WIDTH=8, MAX=255, up from 255 -> dout=0, tc=1.
REQ-036 CNTR_SAT_EN defined: dout=9, up=1, en=1, 2 edges -> dout=9, sat=1 each cycle, tc=0; dout=0, up=0 -> dout=0, sat=1.
